logic_issue: RTL

- Sequential issue/retire stage wrapped around the 32-bit combinational logic unit (AND/OR/NOR/NAND/XOR/XNOR/NOT/2's-complement, 3-bit select).
- Accepts tagged operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered operands and select into the logic unit, then captures its result into a tagged, back-pressurable output register.
- Sits between the decode/operand-read stage and the writeback arbiter.

---
 rtl/logic_pkg.sv | 24 ++
 rtl/logic_req_fifo.sv | 46 ++++
 rtl/logic_issue.sv | 109 ++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
// logic_pkg: shared constants for the logic-unit issue/retire stage
package logic_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;

    // Logic unit select encoding
    localparam logic [SEL_W-1:0] LOP_AND  = 3'b000;
    localparam logic [SEL_W-1:0] LOP_XOR  = 3'b001;
    localparam logic [SEL_W-1:0] LOP_NOR  = 3'b010;
    localparam logic [SEL_W-1:0] LOP_NOT  = 3'b011;
    localparam logic [SEL_W-1:0] LOP_OR   = 3'b100;
    localparam logic [SEL_W-1:0] LOP_XNOR = 3'b101;
    localparam logic [SEL_W-1:0] LOP_NAND = 3'b110;
    localparam logic [SEL_W-1:0] LOP_NEG  = 3'b111;

    typedef logic [DATA_W-1:0] word_t;

    // Width of one buffered request: tag, select, operand B, operand A
    function automatic int entry_w(input int tag_w);
        return tag_w + SEL_W + 2 * DATA_W;
    endfunction

endpackage

// File: rtl/logic_req_fifo.sv
// logic_req_fifo: circular request buffer with wrap-bit pointers
module logic_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 71
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];

    // Pointer advance; guarded so callers cannot overrun or underrun
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + PTR_ONE;
            if (pop && !empty)
                rp <= rp + PTR_ONE;
        end
    end

    // Storage is unreset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/logic_issue.sv
// logic_issue: buffers tagged logic-unit requests, issues operands, retires results
module logic_issue
    import logic_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [2:0]        in_sel,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [31:0]       lu_a,
    output logic [31:0]       lu_b,
    output logic [2:0]        lu_sel,
    input  logic [31:0]       lu_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam int EW = entry_w(TAG_W);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             fifo_full;
    logic             fifo_empty;
    logic [EW-1:0]    fifo_head;
    logic             push;
    logic             issue_load;
    logic             out_load;
    logic             issue_vld;
    logic [TAG_W-1:0] issue_tag;
    logic [TAG_W-1:0] h_tag;
    logic [2:0]       h_sel;
    word_t            h_a;
    word_t            h_b;

    // No bypass: a pop in the same cycle does not reopen a full buffer
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign out_load   = issue_vld && (!out_valid || out_ready);
    assign issue_load = !fifo_empty && (!issue_vld || out_load);
    assign busy       = !fifo_empty || issue_vld || out_valid;
    assign {h_tag, h_sel, h_b, h_a} = fifo_head;

    logic_req_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue_load),
        .din   ({in_tag, in_sel, in_b, in_a}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Issue register drives the external logic unit from the buffer head
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_vld <= 1'b0;
            lu_a      <= '0;
            lu_b      <= '0;
            lu_sel    <= '0;
            issue_tag <= '0;
        end else if (issue_load) begin
            issue_vld <= 1'b1;
            lu_a      <= h_a;
            lu_b      <= h_b;
            lu_sel    <= h_sel;
            issue_tag <= h_tag;
        end else if (out_load) begin
            issue_vld <= 1'b0;
        end
    end

    // Result register captures the logic unit output and holds under back-pressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_data  <= lu_out;
            out_tag   <= issue_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count accepted results, wrapping naturally at the counter width
    always_ff @(posedge clk) begin
        if (rst)
            retired_cnt <= '0;
        else if (out_valid && out_ready)
            retired_cnt <= retired_cnt + CNT_ONE;
    end

endmodule
